// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
// Contents: opcode and FSM enums, the flag bundle and the active-low 7-segment table.
package alu_pkg;

   // Opcodes; values 10..15 are illegal and yield a zero result
   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SHL = 4'd5,
      OP_SHR = 4'd6,
      OP_MUL = 4'd7,
      OP_DIV = 4'd8,
      OP_MOD = 4'd9
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_DIVIDE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic z;
      logic n;
      logic v;
      logic c;
   } flags_t;

   localparam flags_t FLAGS_RST = '{z: 1'b1, n: 1'b0, v: 1'b0, c: 1'b0};

   // Active-low segment codes {g,f,e,d,c,b,a}, indexed by hex digit (entry 15 listed first)
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low 7-segment decoder.
// Ports: hex_i  - 4-bit digit
//        seg_o  - {g,f,e,d,c,b,a}, low = segment lit
module hex_to_7seg
   import alu_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle W-bit ALU behind valid/ready handshakes. Single-cycle ops finish one
// cycle after accept; DIV/MOD use a restoring divider taking W+1 cycles.
// Ports: clk, rst (async active-high)
//        in_valid/in_ready, op, num1, num2  - request side
//        out_valid/out_ready, result, Z, N, V, C, seg - registered response side
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   op,
   input  logic [W-1:0] num1,
   input  logic [W-1:0] num2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         Z,
   output logic         N,
   output logic         V,
   output logic         C,
   output logic [6:0]   seg
);

   localparam int unsigned CW = $clog2(W + 1);
   localparam int unsigned W2 = 2 * W;

   state_t       state_q, state_d;
   logic [3:0]   op_q, op_d;
   logic [W-1:0] a_q, a_d;        // operand A, reused as quotient during divide
   logic [W-1:0] b_q, b_d;
   logic [W-1:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0] result_q, result_d;
   flags_t       flags_q, flags_d;
   logic [6:0]   seg_q, seg_d;
   logic         out_valid_q, out_valid_d;

   logic         accept;
   logic         is_div_op;

   // Handshake: ready only depends on state and consumer readiness
   assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign is_div_op = (op == OP_DIV) | (op == OP_MOD);

   // Single-cycle datapath on latched operands
   logic [W:0]    sum_w, dif_w;
   logic [W2-1:0] shl_w, shr_w, mul_w;
   logic          shift_big;
   logic [W-1:0]  exec_res;
   flags_t        exec_flg;

   always_comb begin
      sum_w     = {1'b0, a_q} + {1'b0, b_q};
      dif_w     = {1'b0, a_q} - {1'b0, b_q};
      shl_w     = {{W{1'b0}}, a_q} << b_q;
      shr_w     = {a_q, {W{1'b0}}} >> b_q;
      mul_w     = W2'(a_q) * W2'(b_q);
      shift_big = (b_q >= W'(W));
      exec_res  = '0;
      exec_flg  = '0;
      case (op_q)
         OP_ADD: begin
            exec_res   = sum_w[W-1:0];
            exec_flg.c = sum_w[W];
            exec_flg.n = exec_res[W-1];
            exec_flg.v = (a_q[W-1] == b_q[W-1]) & (exec_res[W-1] != a_q[W-1]);
         end
         OP_SUB: begin
            exec_res   = dif_w[W-1:0];
            exec_flg.c = dif_w[W];
            exec_flg.n = exec_res[W-1];
            exec_flg.v = (a_q[W-1] != b_q[W-1]) & (exec_res[W-1] != a_q[W-1]);
         end
         OP_AND: exec_res = a_q & b_q;
         OP_OR:  exec_res = a_q | b_q;
         OP_XOR: exec_res = a_q ^ b_q;
         OP_SHL: begin
            // Over-width shifts push every bit out
            if (shift_big) begin
               exec_flg.c = |a_q;
            end else begin
               exec_res   = shl_w[W-1:0];
               exec_flg.c = |shl_w[W2-1:W];
            end
         end
         OP_SHR: begin
            if (shift_big) begin
               exec_flg.c = |a_q;
            end else begin
               exec_res   = shr_w[W2-1:W];
               exec_flg.c = |shr_w[W-1:0];
            end
         end
         OP_MUL: begin
            exec_res   = mul_w[W-1:0];
            exec_flg.c = |mul_w[W2-1:W];
         end
         default: exec_res = '0;
      endcase
      exec_flg.z = (exec_res == '0);
   end

   // Restoring divider step; a zero divisor naturally gives all-ones quotient, remainder = A
   logic [W:0]   div_sh;
   logic [W-1:0] div_sub;
   logic         div_ge;
   logic [W-1:0] div_res;
   flags_t       div_flg;

   always_comb begin
      div_sh     = {rem_q, a_q[W-1]};
      div_sub    = div_sh[W-1:0] - b_q;
      div_ge     = (div_sh >= {1'b0, b_q});
      div_flg    = '0;
      div_res    = (op_q == OP_DIV) ? a_q : rem_q;
      div_flg.z  = (div_res == '0);
      div_flg.v  = (b_q == '0);
      div_flg.c  = (op_q == OP_DIV) & (b_q != '0) & (rem_q != '0);
   end

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: ;
         ST_EXEC: begin
            result_d    = exec_res;
            flags_d     = exec_flg;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DIVIDE: begin
            if (cnt_q == CW'(W)) begin
               result_d    = div_res;
               flags_d     = div_flg;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (div_ge) begin
                  rem_d = div_sub;
                  a_d   = {a_q[W-2:0], 1'b1};
               end else begin
                  rem_d = div_sh[W-1:0];
                  a_d   = {a_q[W-2:0], 1'b0};
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Accept overrides the IDLE/DONE transitions above
      if (accept) begin
         op_d    = op;
         a_d     = num1;
         b_d     = num2;
         rem_d   = '0;
         cnt_d   = '0;
         state_d = is_div_op ? ST_DIVIDE : ST_EXEC;
      end
   end

   // Segment code follows the next result so it loads on the same edge
   hex_to_7seg u_seg (
      .hex_i (result_d[3:0]),
      .seg_o (seg_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         flags_q     <= FLAGS_RST;
         seg_q       <= SEG_TABLE[0];
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         seg_q       <= seg_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign Z         = flags_q.z;
   assign N         = flags_q.n;
   assign V         = flags_q.v;
   assign C         = flags_q.c;
   assign seg       = seg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (W=8): literal vector table plus an arithmetic model
// checked every cycle by a monitor.
module tb_seq_alu;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] num1, num2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         Z, N, V, C;
   logic [6:0]   seg;

   seq_alu #(.W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .Z(Z), .N(N), .V(V), .C(C), .seg(seg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   typedef struct {
      logic [7:0] r;
      logic z, n, v, c;
      int acc;
      int lat;
   } exp_t;

   // Behavioural model from plain integer arithmetic
   function automatic exp_t model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
      exp_t   e;
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint full = 256;
      longint sa, sb, ss, p, rr;
      e.v = 0; e.c = 0; e.n = 0; e.lat = 1; e.acc = 0; rr = 0;
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      case (o)
         4'd0: begin p = ua + ub; rr = p % full; e.c = (p >= full);
                  ss = sa + sb; e.v = (ss > 127) || (ss < -128); e.n = (rr >= 128); end
         4'd1: begin p = ua - ub; rr = (p + full) % full; e.c = (ua < ub);
                  ss = sa - sb; e.v = (ss > 127) || (ss < -128); e.n = (rr >= 128); end
         4'd2: rr = longint'(a & b);
         4'd3: rr = longint'(a | b);
         4'd4: rr = longint'(a ^ b);
         4'd5: if (ub >= 8) begin rr = 0; e.c = (ua != 0); end
               else begin p = ua << ub; rr = p % full; e.c = (p >= full); end
         4'd6: if (ub >= 8) begin rr = 0; e.c = (ua != 0); end
               else begin rr = ua >> ub; e.c = ((ua % (longint'(1) << ub)) != 0); end
         4'd7: begin p = ua * ub; rr = p % full; e.c = (p >= full); end
         4'd8: begin e.lat = 9;
                  if (ub == 0) begin rr = 255; e.v = 1; end
                  else begin rr = ua / ub; e.c = ((ua % ub) != 0); end
               end
         4'd9: begin e.lat = 9;
                  if (ub == 0) begin rr = ua; e.v = 1; end
                  else rr = ua % ub;
               end
         default: rr = 0;
      endcase
      e.r = rr[7:0];
      e.z = (rr == 0);
      return e;
   endfunction

   // Cycle-by-cycle compare against the model queue
   exp_t expq[$];
   logic prev_ov = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         expq.delete();
         prev_ov = 1'b0;
      end else begin
         if (out_valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
               e = expq[0];
               chk("mon_result", 32'(result), 32'(e.r));
               chk("mon_flags", 32'({Z, N, V, C}), 32'({e.z, e.n, e.v, e.c}));
               chk("mon_seg", 32'(seg), 32'(seg_of(e.r[3:0])));
               if (!prev_ov) chk("mon_latency", 32'(cyc - e.acc), 32'(e.lat));
               if (!out_ready) chk("mon_ready_held", 32'(in_ready), 32'd0);
               if (out_ready) void'(expq.pop_front());
            end
         end else begin
            chk("mon_in_ready", 32'(in_ready), 32'(expq.size() == 0));
         end
         if (in_valid && in_ready) begin
            e = model(op, num1, num2);
            e.acc = cyc + 1;
            expq.push_back(e);
         end
         prev_ov = out_valid;
      end
   end

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a, b, r;
      logic z, n, v, c;
   } vec_t;

   vec_t vecs[21];
   int   acc_cyc;

   // Present a request (called just after a rising edge) until it is accepted
   task automatic send(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
      bit got = 0;
      in_valid = 1'b1; op = o; num1 = a; num2 = b;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!got) chk("send_timeout", 32'd0, 32'd1);
      acc_cyc = cyc;
   endtask

   // Wait for out_valid and compare against literal expectations
   task automatic check_lit(input string nm, input logic [7:0] r, input logic [3:0] f,
                            input int lat);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      if (!seen) begin
         chk({nm, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({nm, "_result"}, 32'(result), 32'(r));
         chk({nm, "_flags"}, 32'({Z, N, V, C}), 32'(f));
         chk({nm, "_latency"}, 32'(cyc - acc_cyc), 32'(lat));
      end
   endtask

   initial begin
      vecs[0]  = '{4'd0, 8'hC0, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{4'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{4'd8, 8'hC8, 8'h07, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{4'd9, 8'hC8, 8'h07, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{4'd8, 8'h55, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{4'd9, 8'h55, 8'h00, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{4'd5, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{4'd6, 8'h0A, 8'h09, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{4'd7, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{4'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{4'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{4'd4, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{4'd5, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{4'd6, 8'h81, 8'h01, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[16] = '{4'd5, 8'h01, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[17] = '{4'd12, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{4'd7, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{4'd8, 8'h07, 8'hC8, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[20] = '{4'd9, 8'h07, 8'hC8, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; op = '0; num1 = '0; num2 = '0; out_ready = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", 32'({Z, N, V, C}), 32'b1000);
      chk("rst_seg", 32'(seg), 32'b1000000);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors, consumed as soon as they appear
      for (int i = 0; i < 21; i++) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b);
         check_lit($sformatf("vec%0d", i), vecs[i].r,
                   {vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].c},
                   (vecs[i].op == 4'd8 || vecs[i].op == 4'd9) ? 9 : 1);
         if (i == 3) chk("mod_seg", 32'(seg), 32'b0011001);
         @(posedge clk); #1;
      end

      // Backpressure: result held, request blocked, then overlapping handshake
      out_ready = 1'b0;
      send(4'd0, 8'h01, 8'h02);
      check_lit("bp_add", 8'h03, 4'b0000, 1);
      @(posedge clk); #1;
      in_valid = 1'b1; op = 4'd1; num1 = 8'h09; num2 = 8'h04;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_result", 32'(result), 32'h03);
         chk("bp_seg", 32'(seg), 32'b0110000);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("ov_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      acc_cyc = cyc;
      check_lit("ov_sub", 8'h05, 4'b0000, 1);
      @(posedge clk); #1;

      // Reset in the middle of a divide
      send(4'd8, 8'hC8, 8'h07);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_z", 32'(Z), 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_result", 32'(result), 32'd0);
      @(posedge clk); #1;
      send(4'd0, 8'h02, 8'h03);
      check_lit("post_rst_add", 8'h05, 4'b0000, 1);
      repeat (12) @(posedge clk);
      #1;
      chk("queue_drained", 32'(expq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
